e_muldiv_unit: RTL and testbench

//  Execute-stage multiply/divide unit with architectural HI/LO registers.

---
 rtl/e_muldiv_unit.sv | 127 ++++++++++++
 tb/tb_e_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run for a fixed number of cycles, and busy is held high while they run.
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  hilo_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi, r_lo, r_hi_nxt, r_lo_nxt;
    logic             r_commit;

    logic        w_is_mul, w_is_div, w_accept, w_mt_ok;
    logic [63:0] w_res;

    function automatic logic [63:0] mul_op(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sgn) return sa * sb;
        return ua * ub;
    endfunction

    // Returns {remainder, quotient}; the INT_MIN / -1 overflow case is pinned explicitly
    function automatic logic [63:0] div_op(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign w_is_mul = (hilo_op == 4'd1) || (hilo_op == 4'd2);
    assign w_is_div = (hilo_op == 4'd3) || (hilo_op == 4'd4);
    assign w_accept = start && !req && (w_is_mul || w_is_div);
    assign w_mt_ok  = !req && ((hilo_op == 4'd7) || (hilo_op == 4'd8));

    always_comb begin
        w_res = 64'd0;
        if (w_is_mul) w_res = mul_op(hilo_op == 4'd1, rs_val, rt_val);
        else          w_res = div_op(hilo_op == 4'd3, rs_val, rt_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_nxt <= '0;
            r_lo_nxt <= '0;
            r_commit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= w_is_mul ? S_MUL : S_DIV;
                        r_cnt    <= w_is_mul ? MUL_LOAD : DIV_LOAD;
                        r_hi_nxt <= w_res[63:32];
                        r_lo_nxt <= w_res[31:0];
                        // A zero divisor still occupies the unit but never commits
                        r_commit <= w_is_mul || (rt_val != 32'd0);
                    end else if (w_mt_ok) begin
                        if (hilo_op == 4'd7) r_hi <= rs_val;
                        else                 r_lo <= rs_val;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == CNT_ONE) begin
                        if (r_commit) begin
                            r_hi <= r_hi_nxt;
                            r_lo <= r_lo_nxt;
                        end
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = start || (r_state != S_IDLE);
    assign hilo_rd = (hilo_op == 4'd5) ? r_hi :
                     (hilo_op == 4'd6) ? r_lo : 32'd0;
    assign hi      = r_hi;
    assign lo      = r_lo;
endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed bench for e_muldiv_unit: expected HI/LO and busy lengths are queued at issue
// and checked when busy drops.
module tb_e_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, req, start;
    logic [3:0]  hilo_op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hilo_rd, hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    int          len_q[$];

    e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .hilo_op(hilo_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hilo_rd(hilo_rd),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a start in the current cycle, check busy in it, then move to cycle t+1
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic rq, input logic [31:0] eh, input logic [31:0] el,
                            input int elen);
        hilo_op = op; rs_val = a; rt_val = b; start = 1'b1; req = rq;
        exp_q.push_back({eh, el});
        len_q.push_back(elen);
        #4;
        chk("busy_start", {31'd0, busy}, 32'd1);
        next_cyc();
        start = 1'b0; hilo_op = 4'd0; req = 1'b0;
    endtask

    // Count cycles until busy drops (bounded), then pop the scoreboard and compare
    task automatic wait_done(input string tag, input int first_c, input int req_cyc);
        int   c;
        logic done;
        logic [63:0] e;
        int   elen;
        c = first_c;
        done = 1'b0;
        while (!done && c <= 60) begin
            req = (c == req_cyc);
            #4;
            if (!busy) done = 1'b1;
            else begin
                c++;
                next_cyc();
            end
        end
        req = 1'b0;
        e = exp_q.pop_front();
        elen = len_q.pop_front();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_len"}, 32'(c), 32'(elen));
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
        next_cyc();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; hilo_op = 4'd0; rs_val = '0; rt_val = '0;
        next_cyc();
        next_cyc();
        #4;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", hilo_rd, 32'd0);
        next_cyc();
        reset = 1'b0;

        start_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 6);
        wait_done("mult", 1, 0);

        start_op(4'd4, 32'd7, 32'd2, 1'b0, 32'd1, 32'd3, 11);
        wait_done("divu", 1, 0);

        start_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 11);
        wait_done("div_neg", 1, 0);

        start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 11);
        wait_done("div_ovf", 1, 0);

        hilo_op = 4'd7; rs_val = 32'h1234;
        next_cyc();
        hilo_op = 4'd0;
        chk("mthi", hi, 32'h1234);

        start_op(4'd3, 32'd99, 32'd0, 1'b0, 32'h1234, 32'h8000_0000, 11);
        wait_done("div0", 1, 0);

        start_op(4'd2, 32'd3, 32'd4, 1'b1, 32'h1234, 32'h8000_0000, 1);
        wait_done("req_start", 1, 0);

        hilo_op = 4'd5;
        start_op(4'd5, 32'd1, 32'd1, 1'b0, 32'h1234, 32'h8000_0000, 1);
        wait_done("bad_op", 1, 0);

        hilo_op = 4'd7; rs_val = 32'hFFFF_0000; req = 1'b1;
        next_cyc();
        hilo_op = 4'd0; req = 1'b0;
        chk("mthi_req", hi, 32'h1234);

        start_op(4'd1, 32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 6);
        wait_done("mult_req", 1, 3);

        start_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'd1, 6);
        wait_done("multu", 1, 0);

        hilo_op = 4'd8; rs_val = 32'hA5A5_A5A5;
        #4;
        chk("mtlo_nobypass", hilo_rd, 32'd0);
        next_cyc();
        hilo_op = 4'd6;
        #4;
        chk("mflo", hilo_rd, 32'hA5A5_A5A5);
        next_cyc();
        hilo_op = 4'd5;
        #4;
        chk("mfhi", hilo_rd, 32'hFFFF_FFFE);
        next_cyc();
        hilo_op = 4'd0;

        start_op(4'd1, 32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 6);
        hilo_op = 4'd7; rs_val = 32'hDEAD_BEEF;
        next_cyc();
        hilo_op = 4'd0;
        chk("mthi_busy", hi, 32'hFFFF_FFFE);
        wait_done("mult_mt", 2, 0);

        // Reset in cycle t+4 of a divide aborts it
        hilo_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        exp_q.push_back(64'd0);
        next_cyc();
        start = 1'b0; hilo_op = 4'd0;
        repeat (3) next_cyc();
        reset = 1'b1;
        #4;
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        next_cyc();
        reset = 1'b0;
        #4;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (12) next_cyc();
        begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("rst_nocommit_hi", hi, e[63:32]);
            chk("rst_nocommit_lo", lo, e[31:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
